// File: rtl/lsu_pkg.sv
// Shared types and byte-lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] f_store_lanes(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return off[1] ? 4'b1100 : 4'b0011;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [31:0] word);
        logic [31:0] w;
        w = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{w[7]}}, w[7:0]};
            F3_H:    return {{16{w[15]}}, w[15:0]};
            F3_W:    return w;
            F3_BU:   return {24'h0, w[7:0]};
            F3_HU:   return {16'h0, w[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  st_byte_en,
    output logic [31:0] st_data,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    always_comb begin
        st_byte_en = f_store_lanes(req_funct3, req_off);
        misaligned = f_misaligned(req_funct3, req_off);
        ld_data    = f_load_extract(ld_funct3, ld_off, ld_word);
        case (req_funct3)
            F3_B:    st_data = {4{req_wdata[7:0]}};
            F3_H:    st_data = {2{req_wdata[15:0]}};
            default: st_data = req_wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one RV32I load/store at a time against a fixed-latency word memory.
//   state | meaning
//   IDLE  | ready for a request; memory port parked (read, no lanes)
//   ISSUE | memory driven from the accepted request; stores commit at the end
//   WAIT  | load read latency counted down; data captured on the last cycle
//   RESP  | response held until accepted
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              in_req_valid,
    output logic              out_req_ready,
    input  logic              in_req_we,
    input  logic [2:0]        in_req_funct3,
    input  logic [31:0]       in_req_addr,
    input  logic [31:0]       in_req_wdata,
    output logic              out_rsp_valid,
    input  logic              in_rsp_ready,
    output logic [31:0]       out_rsp_rdata,
    output logic              out_rsp_err,
    output logic [MEM_AW-1:0] out_mem_addr,
    output logic              out_mem_re_web,
    output logic [31:0]       out_mem_write_data,
    output logic [3:0]        out_mem_byte_en,
    input  logic [31:0]       in_mem_data
);

    localparam int CW = $clog2(RD_LAT + 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt_q, cnt_nxt;
    logic              we_q, we_nxt;
    logic [2:0]        f3_q, f3_nxt;
    logic [1:0]        off_q, off_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt, re_web_nxt;
    logic [31:0]       rsp_rdata_nxt, wdata_nxt;
    logic [3:0]        byte_en_nxt;
    logic [MEM_AW-1:0] addr_nxt;

    logic [3:0]  st_byte_en;
    logic [31:0] st_data, ld_data;
    logic        misaligned, f3_legal, range_err, req_err;

    lsu_align u_align (
        .req_funct3 (in_req_funct3),
        .req_off    (in_req_addr[1:0]),
        .req_wdata  (in_req_wdata),
        .st_byte_en (st_byte_en),
        .st_data    (st_data),
        .misaligned (misaligned),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .ld_word    (in_mem_data),
        .ld_data    (ld_data)
    );

    assign out_req_ready = (state == IDLE);

    assign f3_legal  = in_req_we ? (in_req_funct3 inside {F3_B, F3_H, F3_W})
                                 : (in_req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign range_err = |in_req_addr[31:MEM_AW+2];
    assign req_err   = !f3_legal || misaligned || range_err;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_q;
        we_nxt        = we_q;
        f3_nxt        = f3_q;
        off_nxt       = off_q;
        rsp_valid_nxt = out_rsp_valid;
        rsp_err_nxt   = out_rsp_err;
        rsp_rdata_nxt = out_rsp_rdata;
        re_web_nxt    = 1'b1;
        byte_en_nxt   = 4'b0000;
        wdata_nxt     = 32'h0;
        addr_nxt      = out_mem_addr;
        case (state)
            IDLE: begin
                if (in_req_valid) begin
                    we_nxt        = in_req_we;
                    f3_nxt        = in_req_funct3;
                    off_nxt       = in_req_addr[1:0];
                    rsp_rdata_nxt = 32'h0;
                    rsp_err_nxt   = req_err;
                    if (req_err) begin
                        rsp_valid_nxt = 1'b1;
                        state_nxt     = RESP;
                    end else begin
                        addr_nxt  = in_req_addr[MEM_AW+1:2];
                        state_nxt = ISSUE;
                        if (in_req_we) begin
                            re_web_nxt  = 1'b0;
                            byte_en_nxt = st_byte_en;
                            wdata_nxt   = st_data;
                        end
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt   = CW'(RD_LAT - 1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_rdata_nxt = ld_data;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (in_rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Async reset clears byte_en at once, so a store caught in ISSUE never commits.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state              <= IDLE;
            cnt_q              <= '0;
            we_q               <= 1'b0;
            f3_q               <= 3'b000;
            off_q              <= 2'b00;
            out_rsp_valid      <= 1'b0;
            out_rsp_err        <= 1'b0;
            out_rsp_rdata      <= 32'h0;
            out_mem_re_web     <= 1'b1;
            out_mem_byte_en    <= 4'b0000;
            out_mem_write_data <= 32'h0;
            out_mem_addr       <= '0;
        end else begin
            state              <= state_nxt;
            cnt_q              <= cnt_nxt;
            we_q               <= we_nxt;
            f3_q               <= f3_nxt;
            off_q              <= off_nxt;
            out_rsp_valid      <= rsp_valid_nxt;
            out_rsp_err        <= rsp_err_nxt;
            out_rsp_rdata      <= rsp_rdata_nxt;
            out_mem_re_web     <= re_web_nxt;
            out_mem_byte_en    <= byte_en_nxt;
            out_mem_write_data <= wdata_nxt;
            out_mem_addr       <= addr_nxt;
        end
    end

endmodule
